pc_sequencer: RTL and testbench

Program-counter sequencer for the core's fetch stage. It owns the PC register and handshakes with instruction memory. It consumes the branch decision (PCSrc) and a jump request to redirect fetch, then inserts a configurable flush bubble after every taken redirect. It also traps misaligned targets and halts on request.

---
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage PC sequencer with redirect, flush bubble, halt and
//            misaligned-target trap.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_PC     = 32'h0000_0000,
    parameter int                FLUSH_CYCLES = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              PCSrc,
    input  logic              jump,
    input  logic [XLEN-1:0]   target,
    input  logic              halt_req,
    output logic [XLEN-1:0]   pc,
    output logic              imem_req,
    output logic              instr_valid,
    output logic              flush,
    output logic              halted,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] c_flush_load = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [3:0]         fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic               err_q, err_d;
    logic               w_adv;
    logic               w_redirect;

    assign w_adv      = (state_q == ST_FETCH) & imem_ready & ~stall;
    assign w_redirect = PCSrc | jump;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        rcnt_d  = rcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (w_adv) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (w_redirect) begin
                        if (target[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_d = target;
                            if (!(&rcnt_q)) begin
                                rcnt_d = rcnt_q + CNT_W'(1);
                            end
                            if (FLUSH_CYCLES > 0) begin
                                state_d = ST_FLUSH;
                                fcnt_d  = c_flush_load;
                            end
                        end
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            ST_FLUSH: begin
                // Counter reaching zero marks the last bubble cycle.
                if (fcnt_q == 4'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fcnt_q  <= 4'd0;
            rcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
        end
    end

    assign pc             = pc_q;
    assign imem_req       = (state_q == ST_FETCH);
    assign instr_valid    = w_adv;
    assign flush          = (state_q == ST_FLUSH);
    assign halted         = (state_q == ST_HALT);
    assign misalign_err   = err_q;
    assign redirect_count = rcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer over three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic [2:0]  rst, ready, stall, pcsrc, jump, hreq;
    logic [31:0] tgt [3];

    wire  [31:0] pc_o  [3];
    wire  [15:0] cnt_o [3];
    wire  [1:0]  cnt1;
    wire  [2:0]  req_o, iv_o, fl_o, ha_o, me_o;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Model state: remaining bubbles and boot/halt flags rather than an FSM.
    int          m_boot [3];
    int          m_bub  [3];
    bit          m_halt [3];
    logic [31:0] m_pc   [3];
    int          m_cnt  [3];
    bit          m_err  [3];

    int          fc   [3] = '{1, 1, 3};
    int          cmax [3] = '{65535, 3, 65535};
    logic [31:0] rpc  [3] = '{32'h0, 32'hFFFF_FFFC, 32'h0};

    always #5 clk = ~clk;

    pc_sequencer u0 (
        .clk(clk), .reset(rst[0]), .imem_ready(ready[0]), .stall(stall[0]),
        .PCSrc(pcsrc[0]), .jump(jump[0]), .target(tgt[0]), .halt_req(hreq[0]),
        .pc(pc_o[0]), .imem_req(req_o[0]), .instr_valid(iv_o[0]), .flush(fl_o[0]),
        .halted(ha_o[0]), .misalign_err(me_o[0]), .redirect_count(cnt_o[0])
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u1 (
        .clk(clk), .reset(rst[1]), .imem_ready(ready[1]), .stall(stall[1]),
        .PCSrc(pcsrc[1]), .jump(jump[1]), .target(tgt[1]), .halt_req(hreq[1]),
        .pc(pc_o[1]), .imem_req(req_o[1]), .instr_valid(iv_o[1]), .flush(fl_o[1]),
        .halted(ha_o[1]), .misalign_err(me_o[1]), .redirect_count(cnt1)
    );
    assign cnt_o[1] = {14'd0, cnt1};

    pc_sequencer #(.FLUSH_CYCLES(3)) u2 (
        .clk(clk), .reset(rst[2]), .imem_ready(ready[2]), .stall(stall[2]),
        .PCSrc(pcsrc[2]), .jump(jump[2]), .target(tgt[2]), .halt_req(hreq[2]),
        .pc(pc_o[2]), .imem_req(req_o[2]), .instr_valid(iv_o[2]), .flush(fl_o[2]),
        .halted(ha_o[2]), .misalign_err(me_o[2]), .redirect_count(cnt_o[2])
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: actual=%h expected=%h @%0t", name, k, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                m_boot[k] <= 1; m_bub[k] <= 0; m_halt[k] <= 1'b0;
                m_pc[k] <= rpc[k]; m_cnt[k] <= 0; m_err[k] <= 1'b0;
            end else if (m_boot[k] != 0) begin
                m_boot[k] <= 0;
            end else if (m_halt[k]) begin
                m_halt[k] <= 1'b1;
            end else if (m_bub[k] > 0) begin
                m_bub[k] <= m_bub[k] - 1;
            end else if (ready[k] && !stall[k]) begin
                if (hreq[k]) begin
                    m_halt[k] <= 1'b1;
                end else if (pcsrc[k] || jump[k]) begin
                    if (tgt[k] % 4 != 0) begin
                        m_err[k] <= 1'b1; m_halt[k] <= 1'b1;
                    end else begin
                        m_pc[k]  <= tgt[k];
                        m_cnt[k] <= (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : cmax[k];
                        m_bub[k] <= fc[k];
                    end
                end else begin
                    m_pc[k] <= m_pc[k] + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                logic ereq;
                ereq = (m_boot[k] == 0) && (m_bub[k] == 0) && !m_halt[k];
                check("pc",      k, pc_o[k], m_pc[k]);
                check("imem_req", k, {31'd0, req_o[k]}, {31'd0, ereq});
                check("instr_valid", k, {31'd0, iv_o[k]}, {31'd0, ereq & ready[k] & ~stall[k]});
                check("flush",   k, {31'd0, fl_o[k]}, {31'd0, m_bub[k] > 0});
                check("halted",  k, {31'd0, ha_o[k]}, {31'd0, m_halt[k]});
                check("misalign", k, {31'd0, me_o[k]}, {31'd0, m_err[k]});
                check("count",   k, {16'd0, cnt_o[k]}, m_cnt[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 3'b111; ready = '0; stall = '0; pcsrc = '0; jump = '0; hreq = '0;
        for (int k = 0; k < 3; k++) tgt[k] = '0;
        tick();
        started = 1'b1;
        tick();
        check("lit_rst_pc", 0, pc_o[0], 32'h0);
        check("lit_rst_req", 0, {31'd0, req_o[0]}, 32'd0);
        check("lit_rst_cnt", 0, {16'd0, cnt_o[0]}, 32'd0);

        // Free run, then taken branch at pc=8.
        rst[0] = 1'b0; ready[0] = 1'b1;
        check("lit_boot_req", 0, {31'd0, req_o[0]}, 32'd0);
        tick(); check("lit_pc0", 0, pc_o[0], 32'h0); check("lit_iv", 0, {31'd0, iv_o[0]}, 32'd1);
        tick(); check("lit_pc4", 0, pc_o[0], 32'h4);
        tick(); check("lit_pc8", 0, pc_o[0], 32'h8);
        pcsrc[0] = 1'b1; tgt[0] = 32'h100;
        tick(); pcsrc[0] = 1'b0;
        check("lit_br_pc", 0, pc_o[0], 32'h100);
        check("lit_br_flush", 0, {31'd0, fl_o[0]}, 32'd1);
        check("lit_br_req", 0, {31'd0, req_o[0]}, 32'd0);
        tick();
        check("lit_br_req2", 0, {31'd0, req_o[0]}, 32'd1);
        check("lit_br_cnt", 0, {16'd0, cnt_o[0]}, 32'd1);

        // Jump to 0x20, then stall and not-ready windows.
        jump[0] = 1'b1; tgt[0] = 32'h20;
        tick(); jump[0] = 1'b0;
        tick();
        stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("lit_stall_pc", 0, pc_o[0], 32'h20);
        end
        stall[0] = 1'b0; ready[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); check("lit_wait_req", 0, {31'd0, req_o[0]}, 32'd1);
        end
        ready[0] = 1'b1;
        tick(); check("lit_rel_pc", 0, pc_o[0], 32'h24);

        // Misaligned jump traps and halts; later inputs are ignored.
        jump[0] = 1'b1; tgt[0] = 32'h102;
        tick(); jump[0] = 1'b0;
        check("lit_mis_err", 0, {31'd0, me_o[0]}, 32'd1);
        check("lit_mis_halt", 0, {31'd0, ha_o[0]}, 32'd1);
        check("lit_mis_pc", 0, pc_o[0], 32'h24);
        pcsrc[0] = 1'b1; hreq[0] = 1'b1; tgt[0] = 32'h200;
        repeat (3) tick();
        check("lit_halt_pc", 0, pc_o[0], 32'h24);
        rst[0] = 1'b1; pcsrc[0] = 1'b0; hreq[0] = 1'b0;
        tick();
        check("lit_clr_err", 0, {31'd0, me_o[0]}, 32'd0);
        check("lit_clr_halt", 0, {31'd0, ha_o[0]}, 32'd0);

        // Wrap from 0xFFFF_FFFC and 2-bit counter saturation.
        rst[1] = 1'b0; ready[1] = 1'b1;
        tick(); check("lit_wrap_pre", 1, pc_o[1], 32'hFFFF_FFFC);
        tick(); check("lit_wrap_pc", 1, pc_o[1], 32'h0);
        for (int i = 1; i <= 5; i++) begin
            pcsrc[1] = 1'b1; jump[1] = (i == 1); tgt[1] = 32'h40 * i;
            tick(); pcsrc[1] = 1'b0; jump[1] = 1'b0;
            tick();
            if (i == 1) check("lit_both_cnt", 1, {16'd0, cnt_o[1]}, 32'd1);
        end
        check("lit_sat_cnt", 1, {16'd0, cnt_o[1]}, 32'd3);
        check("lit_sat_pc", 1, pc_o[1], 32'h140);

        // Reset during the second of three flush cycles.
        rst[2] = 1'b0; ready[2] = 1'b1;
        tick();
        jump[2] = 1'b1; tgt[2] = 32'h80;
        tick(); jump[2] = 1'b0;
        check("lit_f1_flush", 2, {31'd0, fl_o[2]}, 32'd1);
        tick();
        rst[2] = 1'b1;
        tick();
        check("lit_mid_pc", 2, pc_o[2], 32'h0);
        check("lit_mid_flush", 2, {31'd0, fl_o[2]}, 32'd0);
        check("lit_mid_cnt", 2, {16'd0, cnt_o[2]}, 32'd0);
        rst[2] = 1'b0;
        tick();
        jump[2] = 1'b1; tgt[2] = 32'h80;
        tick(); jump[2] = 1'b0;
        tick(); tick();
        check("lit_f3_req", 2, {31'd0, req_o[2]}, 32'd0);
        tick();
        check("lit_f_done", 2, {31'd0, req_o[2]}, 32'd1);
        hreq[2] = 1'b1; pcsrc[2] = 1'b1; tgt[2] = 32'h300;
        tick(); hreq[2] = 1'b0; pcsrc[2] = 1'b0;
        check("lit_hq_halt", 2, {31'd0, ha_o[2]}, 32'd1);
        check("lit_hq_pc", 2, pc_o[2], 32'h80);
        check("lit_hq_cnt", 2, {16'd0, cnt_o[2]}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
